z_result_buf: RTL and testbench

Parametrised successor to the datapath's Z result register. Holds up to DEPTH wide ALU results (MUL/DIV produce W×SLICES bits) in a FIFO and drives one W-bit slice of the oldest result onto the CPU bus per read. An optional auto-sequencer streams all slices of the head result on consecutive cycles and then retires it. Sits between the ALU output and the bus multiplexer, in place of the fixed 64-bit Z register.

---
 rtl/z_result_buf_pkg.sv | 18 +
 rtl/z_result_buf_if.sv | 37 +++
 rtl/z_result_buf_fifo.sv | 66 ++++++
 rtl/z_result_buf.sv | 132 +++++++++++++
 tb/tb_z_result_buf.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/z_result_buf_pkg.sv
// Shared constants and types for the Z result buffer slice.
package z_pkg;

    localparam int unsigned Z_W      = 32;
    localparam int unsigned Z_SLICES = 2;
    localparam int unsigned Z_DEPTH  = 4;

    typedef enum logic {
        Z_IDLE,
        Z_DRIVE
    } z_seq_state_t;

    // Slice-select width; stays 1 bit even for single-slice results.
    function automatic int unsigned z_sel_w(input int unsigned slices);
        return (slices > 1) ? $clog2(slices) : 1;
    endfunction

endpackage

// File: rtl/z_result_buf_if.sv
// Bus-side bundle of the Z result buffer: ALU push/read controls and status.
interface z_result_buf_if
    import z_pkg::*;
#(
    parameter int unsigned W      = Z_W,
    parameter int unsigned SLICES = Z_SLICES,
    parameter int unsigned DEPTH  = Z_DEPTH
);
    localparam int unsigned RW = W * SLICES;
    localparam int unsigned SW = z_sel_w(SLICES);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [RW-1:0] D;
    logic          ZIn;
    logic          ZOut;
    logic [SW-1:0] ZSel;
    logic          ZPop;
    logic          ZSeqStart;
    logic [W-1:0]  Z;
    logic          ZValid;
    logic          ZBusy;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;
    logic          ovf;

    modport master (
        output D, ZIn, ZOut, ZSel, ZPop, ZSeqStart,
        input  Z, ZValid, ZBusy, full, empty, count, ovf
    );

    modport slave (
        input  D, ZIn, ZOut, ZSel, ZPop, ZSeqStart,
        output Z, ZValid, ZBusy, full, empty, count, ovf
    );

endinterface

// File: rtl/z_result_buf_fifo.sv
// Result storage FIFO: array, wrap pointers, occupancy and sticky overflow.
module z_result_fifo #(
    parameter int unsigned RW    = 64,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PW   = $clog2(DEPTH),
    localparam int unsigned CW   = $clog2(DEPTH) + 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [RW-1:0] wdata_i,
    output logic [RW-1:0] head_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o,
    output logic          ovf_o
);

    logic [RW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          push_ok, pop_ok;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);

    // A full buffer is never empty, so a same-cycle pop always makes room.
    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_i);

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        ovf_d   = ovf_q;
        count_d = count_q + CW'(push_ok) - CW'(pop_ok);
        if (push_ok) wptr_d = wptr_q + 1'b1;
        if (pop_ok)  rptr_d = rptr_q + 1'b1;
        if (push_i && !push_ok) ovf_d = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wptr_q] <= wdata_i;
    end

    assign head_o  = mem_q[rptr_q];
    assign count_o = count_q;
    assign ovf_o   = ovf_q;

endmodule

// File: rtl/z_result_buf.sv
// Z result buffer top: FIFO of wide ALU results, slice mux, registered bus output.
// Z_AUTO_SEQ_EN builds the auto-sequencer that streams and retires the head entry.
module z_result_buf
    import z_pkg::*;
#(
    parameter int unsigned W      = Z_W,
    parameter int unsigned SLICES = Z_SLICES,
    parameter int unsigned DEPTH  = Z_DEPTH
) (
    input  logic           clk,
    input  logic           clr,
    z_result_buf_if.slave  zb
);

    localparam int unsigned RW = W * SLICES;
    localparam int unsigned SW = z_sel_w(SLICES);

    logic [RW-1:0] head;
    logic          fifo_empty;
    logic          pop_req;
    logic          rd_en;
    logic [SW-1:0] rd_sel;
    logic [W-1:0]  z_q, z_d;
    logic          zv_q, zv_d;

    z_result_fifo #(
        .RW    (RW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (clr),
        .push_i  (zb.ZIn),
        .pop_i   (pop_req),
        .wdata_i (zb.D),
        .head_o  (head),
        .full_o  (zb.full),
        .empty_o (fifo_empty),
        .count_o (zb.count),
        .ovf_o   (zb.ovf)
    );

    assign zb.empty = fifo_empty;

`ifdef Z_AUTO_SEQ_EN
    z_seq_state_t  state_q, state_d;
    logic [SW-1:0] slc_q, slc_d;

    always_ff @(posedge clk) begin
        if (!clr) begin
            state_q <= Z_IDLE;
            slc_q   <= '0;
        end else begin
            state_q <= state_d;
            slc_q   <= slc_d;
        end
    end

    // Sequencer owns the read/pop path whenever it is starting or driving.
    always_comb begin
        state_d = state_q;
        slc_d   = slc_q;
        rd_en   = zb.ZOut;
        rd_sel  = zb.ZSel;
        pop_req = zb.ZPop;
        case (state_q)
            Z_IDLE: begin
                if (zb.ZSeqStart && !fifo_empty) begin
                    state_d = Z_DRIVE;
                    slc_d   = '0;
                    rd_en   = 1'b0;
                    pop_req = 1'b0;
                end
            end
            Z_DRIVE: begin
                rd_en   = 1'b1;
                rd_sel  = slc_q;
                pop_req = 1'b0;
                if (slc_q == SW'(SLICES - 1)) begin
                    pop_req = 1'b1;
                    state_d = Z_IDLE;
                    slc_d   = '0;
                end else begin
                    slc_d = slc_q + 1'b1;
                end
            end
            default: state_d = Z_IDLE;
        endcase
    end

    assign zb.ZBusy = (state_q == Z_DRIVE);
`else
    logic unused_seq_start;

    assign unused_seq_start = zb.ZSeqStart;

    always_comb begin
        rd_en   = zb.ZOut;
        rd_sel  = zb.ZSel;
        pop_req = zb.ZPop;
    end

    assign zb.ZBusy = 1'b0;
`endif

    // Out-of-range selects match no slice and leave the bus at zero.
    always_comb begin
        z_d  = '0;
        zv_d = 1'b0;
        if (rd_en && !fifo_empty) begin
            for (int unsigned k = 0; k < SLICES; k++) begin
                if (rd_sel == SW'(k)) begin
                    z_d  = head[k*W +: W];
                    zv_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            z_q  <= '0;
            zv_q <= 1'b0;
        end else begin
            z_q  <= z_d;
            zv_q <= zv_d;
        end
    end

    assign zb.Z      = z_q;
    assign zb.ZValid = zv_q;

endmodule

// File: tb/tb_z_result_buf.sv
// Randomized self-checking bench for z_result_buf against a queue-based model.
module tb_z_result_buf;

    localparam int unsigned W      = 32;
    localparam int unsigned SLICES = 2;
    localparam int unsigned DEPTH  = 4;

    logic clk = 1'b0;
    logic clr = 1'b0;

    always #5 clk = ~clk;

    z_result_buf_if #(.W(W), .SLICES(SLICES), .DEPTH(DEPTH)) zb ();

    z_result_buf #(.W(W), .SLICES(SLICES), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .clr (clr),
        .zb  (zb)
    );

    int unsigned checks = 0;
    int unsigned errors = 0;

    logic [63:0] m_q[$];
    bit          m_ovf  = 1'b0;
    bit          m_busy = 1'b0;
    int unsigned m_slice = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        zb.D = '0; zb.ZIn = 1'b0; zb.ZOut = 1'b0; zb.ZSel = '0;
        zb.ZPop = 1'b0; zb.ZSeqStart = 1'b0;
    endtask

    function automatic logic [31:0] slice_of(input logic [63:0] v, input int unsigned s);
        return 32'(v >> (32 * s));
    endfunction

    // Predict one clock from the current inputs, advance, then compare everything.
    task automatic step();
        logic [31:0] exp_z  = '0;
        bit          exp_zv = 1'b0;
        bit          do_pop = 1'b0;
        bit          do_push;
        bit          manual = 1'b1;
        if (!clr) begin
            m_q.delete();
            m_ovf = 1'b0; m_busy = 1'b0; m_slice = 0;
        end else begin
`ifdef Z_AUTO_SEQ_EN
            if (m_busy) begin
                manual = 1'b0;
                exp_z  = slice_of(m_q[0], m_slice);
                exp_zv = 1'b1;
                if (m_slice == SLICES - 1) begin
                    do_pop = 1'b1; m_busy = 1'b0; m_slice = 0;
                end else begin
                    m_slice++;
                end
            end else if (zb.ZSeqStart && m_q.size() > 0) begin
                manual = 1'b0; m_busy = 1'b1; m_slice = 0;
            end
`endif
            if (manual) begin
                if (zb.ZOut && m_q.size() > 0 && zb.ZSel < SLICES) begin
                    exp_z  = slice_of(m_q[0], zb.ZSel);
                    exp_zv = 1'b1;
                end
                do_pop = zb.ZPop && m_q.size() > 0;
            end
            do_push = zb.ZIn && (m_q.size() < DEPTH || do_pop);
            if (zb.ZIn && !do_push) m_ovf = 1'b1;
            if (do_pop)  void'(m_q.pop_front());
            if (do_push) m_q.push_back(zb.D);
        end
        @(posedge clk);
        #1;
        chk("Z",      64'(zb.Z),      64'(exp_z));
        chk("ZValid", 64'(zb.ZValid), 64'(exp_zv));
        chk("ZBusy",  64'(zb.ZBusy),  64'(m_busy));
        chk("count",  64'(zb.count),  64'(m_q.size()));
        chk("full",   64'(zb.full),   64'(m_q.size() == DEPTH));
        chk("empty",  64'(zb.empty),  64'(m_q.size() == 0));
        chk("ovf",    64'(zb.ovf),    64'(m_ovf));
    endtask

    task automatic push(input logic [63:0] d);
        idle_inputs(); zb.ZIn = 1'b1; zb.D = d; step();
    endtask

    task automatic read_pop(input logic [31:0] exp_lo);
        idle_inputs(); zb.ZOut = 1'b1; zb.ZSel = '0; zb.ZPop = 1'b1; step();
        chk("fifo_order", 64'(zb.Z), 64'(exp_lo));
    endtask

    initial begin
        logic [63:0] vals[5];
        vals[0] = 64'hA0A0_A0A0_A000_000A;
        vals[1] = 64'hB0B0_B0B0_B000_000B;
        vals[2] = 64'hC0C0_C0C0_C000_000C;
        vals[3] = 64'hD0D0_D0D0_D000_000D;
        vals[4] = 64'hE0E0_E0E0_E000_000E;

        idle_inputs();
        clr = 1'b0;
        step();
        step();
        chk("rst_empty", 64'(zb.empty), 64'd1);
        clr = 1'b1;

        // Single result, both slices, then idle bus.
        push(64'h1111_2222_3333_4444);
        idle_inputs(); zb.ZOut = 1'b1; zb.ZSel = 1'b0; step();
        chk("slice0", 64'(zb.Z), 64'h3333_4444);
        idle_inputs(); zb.ZOut = 1'b1; zb.ZSel = 1'b1; step();
        chk("slice1", 64'(zb.Z), 64'h1111_2222);
        idle_inputs(); step();
        chk("idle_zero", 64'(zb.Z), 64'd0);
        idle_inputs(); zb.ZPop = 1'b1; step();

        // Fill, overflow, drain in order.
        for (int i = 0; i < 5; i++) push(vals[i]);
        chk("ovf_set", 64'(zb.ovf), 64'd1);
        chk("full_set", 64'(zb.full), 64'd1);
        for (int i = 0; i < 4; i++) read_pop(slice_of(vals[i], 0));
        idle_inputs(); step();
        chk("drained", 64'(zb.empty), 64'd1);

        // Push and pop together while full; wrap-around of both pointers.
        for (int i = 0; i < 4; i++) push(vals[i]);
        idle_inputs(); zb.ZIn = 1'b1; zb.D = 64'hF0F0_F0F0_F000_000F; zb.ZPop = 1'b1; step();
        chk("full_pushpop_cnt", 64'(zb.count), 64'd4);
        for (int i = 1; i < 4; i++) read_pop(slice_of(vals[i], 0));
        read_pop(32'hF000_000F);

        // Empty: read and pop are ignored; push with pop on empty keeps the push.
        idle_inputs(); zb.ZOut = 1'b1; zb.ZPop = 1'b1; step();
        chk("empty_read", 64'(zb.ZValid), 64'd0);
        idle_inputs(); zb.ZIn = 1'b1; zb.D = vals[2]; zb.ZPop = 1'b1; step();
        chk("empty_pushpop", 64'(zb.count), 64'd1);
        idle_inputs(); zb.ZPop = 1'b1; step();

`ifdef Z_AUTO_SEQ_EN
        push(64'hAAAA_BBBB_CCCC_DDDD);
        idle_inputs(); zb.ZSeqStart = 1'b1; step();
        chk("seq_busy", 64'(zb.ZBusy), 64'd1);
        idle_inputs(); zb.ZPop = 1'b1; step();
        chk("seq_s0", 64'(zb.Z), 64'hCCCC_DDDD);
        idle_inputs(); zb.ZPop = 1'b1; step();
        chk("seq_s1", 64'(zb.Z), 64'hAAAA_BBBB);
        chk("seq_done", 64'(zb.empty), 64'd1);
        idle_inputs(); step();
        push(vals[0]);
        push(vals[1]);
        idle_inputs(); zb.ZSeqStart = 1'b1; step();
        idle_inputs(); step();
        clr = 1'b0; step(); clr = 1'b1;
        chk("seq_clr_busy", 64'(zb.ZBusy), 64'd0);
        chk("seq_clr_cnt", 64'(zb.count), 64'd0);
`endif

        // Random traffic with occasional resets.
        for (int n = 0; n < 600; n++) begin
            clr          = ($urandom_range(0, 59) != 0);
            zb.D         = {$urandom(), $urandom()};
            zb.ZIn       = ($urandom_range(0, 2) == 0);
            zb.ZOut      = ($urandom_range(0, 1) == 0);
            zb.ZSel      = 1'($urandom_range(0, 1));
            zb.ZPop      = ($urandom_range(0, 3) == 0);
            zb.ZSeqStart = ($urandom_range(0, 7) == 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
